// File: rtl/ym6045c_bus_arbiter_fsm.sv
// 68k bus arbiter between the Z80 bank window and VDP DMA: runs BR/BG/BGACK,
// stretches Z80 WAIT over a window access and owns the 9-bit Z80 bank register.
module ym6045c_bus_arbiter_fsm #(
    parameter int ACC_CYCLES = 4,
    parameter int BG_TIMEOUT = 63
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        z80_win_req,
    input  logic [14:0] z80_addr,
    input  logic        z80_bank_wr,
    input  logic        z80_bank_din,
    output logic        z80_wait,
    input  logic        dma_req,
    output logic        dma_gnt,
    output logic        m68k_br,
    input  logic        m68k_bg,
    input  logic        m68k_as,
    output logic        m68k_bgack,
    output logic [23:0] bus_addr,
    output logic [1:0]  bus_owner,
    output logic        timeout_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ACK  = 3'd2;
    localparam logic [2:0] S_Z80  = 3'd3;
    localparam logic [2:0] S_DMA  = 3'd4;
    localparam logic [2:0] S_REL  = 3'd5;

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);
    localparam logic [7:0] TCNT_MAX = 8'(BG_TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [8:0]  bank_q, bank_d;
    logic [8:0]  lat_bank_q;
    logic [14:0] lat_addr_q;
    logic        granted, any_req, xfer_last;

    assign granted   = m68k_bg & ~m68k_as;
    assign any_req   = dma_req | z80_win_req;
    assign xfer_last = (state_q == S_Z80) && (cnt_q == CNT_LAST);

    // New bank bit enters at the top; nine writes fill the register.
    assign bank_d = z80_bank_wr ? {z80_bank_din, bank_q[8:1]} : bank_q;

    always_comb begin
        state_d     = state_q;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE: if (any_req) state_d = S_REQ;
            S_REQ: begin
                if (granted)                   state_d = S_ACK;
                else if (!any_req)             state_d = S_IDLE;
                else if (tcnt_q == TCNT_MAX) begin
                    state_d     = S_IDLE;
                    timeout_err = 1'b1;
                end
            end
            S_ACK: begin
                if (dma_req)          state_d = S_DMA;
                else if (z80_win_req) state_d = S_Z80;
                else                  state_d = S_REL;
            end
            S_Z80: if (xfer_last) state_d = dma_req ? S_ACK : S_REL;
            S_DMA: if (!dma_req) state_d = z80_win_req ? S_ACK : S_REL;
            S_REL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Both counters restart on any state change.
    always_comb begin
        cnt_d  = cnt_q;
        tcnt_d = tcnt_q;
        if (state_d != state_q) begin
            cnt_d  = 4'd0;
            tcnt_d = 8'd0;
        end else begin
            if (state_q == S_Z80) cnt_d  = cnt_q + 4'd1;
            if (state_q == S_REQ) tcnt_d = tcnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            tcnt_q     <= 8'd0;
            bank_q     <= 9'd0;
            lat_bank_q <= 9'd0;
            lat_addr_q <= 15'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            bank_q  <= bank_d;
            // Latch uses bank_d so a write on the entry edge is included.
            if (state_d == S_Z80 && state_q != S_Z80) begin
                lat_bank_q <= bank_d;
                lat_addr_q <= z80_addr;
            end
        end
    end

    assign m68k_br    = (state_q == S_REQ);
    assign m68k_bgack = (state_q == S_ACK) || (state_q == S_Z80) || (state_q == S_DMA);
    assign dma_gnt    = (state_q == S_DMA);
    assign bus_owner  = (state_q == S_Z80) ? 2'd1 : (state_q == S_DMA) ? 2'd2 : 2'd0;
    assign z80_wait   = z80_win_req & ~xfer_last;
    assign bus_addr   = {lat_bank_q, lat_addr_q};

endmodule

// File: tb/tb_ym6045c_bus_arbiter_fsm.sv
// Bench for the 68k bus arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a phase-level reference model.
module tb_ym6045c_bus_arbiter_fsm;

    localparam int ACC = 4;
    localparam int TMO = 63;

    logic        clk = 1'b0;
    logic        rst;
    logic        z80_win_req, z80_bank_wr, z80_bank_din, dma_req, m68k_bg, m68k_as;
    logic [14:0] z80_addr;
    logic        z80_wait, dma_gnt, m68k_br, m68k_bgack, timeout_err;
    logic [23:0] bus_addr;
    logic [1:0]  bus_owner;

    always #5 clk = ~clk;

    ym6045c_bus_arbiter_fsm #(.ACC_CYCLES(ACC), .BG_TIMEOUT(TMO)) dut (
        .CLK(clk), .RESET(rst),
        .z80_win_req(z80_win_req), .z80_addr(z80_addr),
        .z80_bank_wr(z80_bank_wr), .z80_bank_din(z80_bank_din),
        .z80_wait(z80_wait), .dma_req(dma_req), .dma_gnt(dma_gnt),
        .m68k_br(m68k_br), .m68k_bg(m68k_bg), .m68k_as(m68k_as),
        .m68k_bgack(m68k_bgack), .bus_addr(bus_addr),
        .bus_owner(bus_owner), .timeout_err(timeout_err)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: which tenure phase the bus is in and how long it has been there.
    typedef enum int {M_IDLE, M_ASK, M_SETTLE, M_Z80, M_DMA, M_GAP} mph_t;
    mph_t        ph = M_IDLE;
    int          pn = 0;
    bit          bq[$];
    logic [23:0] m_addr = 24'd0;

    function automatic logic [8:0] bank_val();
        logic [8:0] v = 9'd0;
        for (int i = 0; i < bq.size(); i++) v[9 - bq.size() + i] = bq[i];
        return v;
    endfunction

    function automatic logic m_wait();
        return z80_win_req && !(ph == M_Z80 && pn == ACC - 1);
    endfunction

    function automatic logic m_tout();
        return ph == M_ASK && !(m68k_bg && !m68k_as) && (dma_req || z80_win_req) && pn == TMO;
    endfunction

    task automatic model_cmp();
        chk1("br", m68k_br, ph == M_ASK);
        chk1("bgack", m68k_bgack, ph == M_SETTLE || ph == M_Z80 || ph == M_DMA);
        chk1("dma_gnt", dma_gnt, ph == M_DMA);
        chk1("z80_wait", z80_wait, m_wait());
        chk1("timeout_err", timeout_err, m_tout());
        chkw("bus_owner", 32'(bus_owner), (ph == M_Z80) ? 32'd1 : (ph == M_DMA) ? 32'd2 : 32'd0);
        chkw("bus_addr", 32'(bus_addr), 32'(m_addr));
    endtask

    task automatic model_step();
        mph_t nx;
        if (rst) begin
            ph = M_IDLE; pn = 0; bq.delete(); m_addr = 24'd0;
            return;
        end
        if (z80_bank_wr) begin
            bq.push_back(z80_bank_din);
            if (bq.size() > 9) void'(bq.pop_front());
        end
        nx = ph;
        case (ph)
            M_IDLE:   if (dma_req || z80_win_req) nx = M_ASK;
            M_ASK:    if (m68k_bg && !m68k_as) nx = M_SETTLE;
                      else if (!dma_req && !z80_win_req) nx = M_IDLE;
                      else if (pn == TMO) nx = M_IDLE;
            M_SETTLE: nx = dma_req ? M_DMA : z80_win_req ? M_Z80 : M_GAP;
            M_Z80:    if (pn == ACC - 1) nx = dma_req ? M_SETTLE : M_GAP;
            M_DMA:    if (!dma_req) nx = z80_win_req ? M_SETTLE : M_GAP;
            M_GAP:    nx = M_IDLE;
            default:  nx = M_IDLE;
        endcase
        if (nx == M_Z80 && ph != M_Z80) m_addr = {bank_val(), z80_addr};
        pn = (nx == ph) ? pn + 1 : 0;
        ph = nx;
    endtask

    task automatic tick();
        @(negedge clk);
        model_cmp();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic finish_z80();
        int k = 0;
        while (z80_wait && k < 40) begin tick(); k++; end
        chk1("access completes", z80_wait, 1'b0);
        tick();
        z80_win_req = 1'b0;
        tick();
        tick();
    endtask

    // Field order: req dma bg as chk_addr | br bgack wait gnt | owner
    typedef struct packed {
        logic req, dma, bg, as_, ca;
        logic br, ack, wt, gnt;
        logic [1:0] own;
    } vec_t;
    vec_t tbl[12];

    int   c;
    logic lowseen;
    bit   no_bg;

    initial begin
        tbl[0]  = 11'b10000_0010_00;
        tbl[1]  = 11'b10000_1010_00;
        tbl[2]  = 11'b10000_1010_00;
        tbl[3]  = 11'b10000_1010_00;
        tbl[4]  = 11'b10100_1010_00;
        tbl[5]  = 11'b10100_0110_00;
        tbl[6]  = 11'b10001_0110_01;
        tbl[7]  = 11'b10000_0110_01;
        tbl[8]  = 11'b10000_0110_01;
        tbl[9]  = 11'b10000_0100_01;
        tbl[10] = 11'b00000_0000_00;
        tbl[11] = 11'b00000_0000_00;

        rst = 1'b1; z80_win_req = 1'b0; z80_addr = 15'd0; z80_bank_wr = 1'b0;
        z80_bank_din = 1'b0; dma_req = 1'b0; m68k_bg = 1'b0; m68k_as = 1'b0;
        repeat (2) @(posedge clk);
        model_step();
        #1;
        chk1("rst br", m68k_br, 1'b0);
        chk1("rst bgack", m68k_bgack, 1'b0);
        chk1("rst gnt", dma_gnt, 1'b0);
        chk1("rst wait", z80_wait, 1'b0);
        chk1("rst tout", timeout_err, 1'b0);
        chkw("rst owner", 32'(bus_owner), 32'd0);
        chkw("rst addr", 32'(bus_addr), 32'd0);
        rst = 1'b0;

        // T1: load bank 9'h155, then T2 vector table with the access to 0x1234
        for (int i = 0; i < 9; i++) begin
            z80_bank_wr = 1'b1; z80_bank_din = (i % 2 == 0);
            tick();
        end
        z80_bank_wr = 1'b0;
        z80_addr = 15'h1234;
        for (int i = 0; i < 12; i++) begin
            z80_win_req = tbl[i].req; dma_req = tbl[i].dma;
            m68k_bg = tbl[i].bg; m68k_as = tbl[i].as_;
            #2;
            chk1($sformatf("T2[%0d] br", i), m68k_br, tbl[i].br);
            chk1($sformatf("T2[%0d] bgack", i), m68k_bgack, tbl[i].ack);
            chk1($sformatf("T2[%0d] wait", i), z80_wait, tbl[i].wt);
            chk1($sformatf("T2[%0d] gnt", i), dma_gnt, tbl[i].gnt);
            chkw($sformatf("T2[%0d] owner", i), 32'(bus_owner), 32'(tbl[i].own));
            if (tbl[i].ca) chkw("T1 bus_addr", 32'(bus_addr), 32'hAA9234);
            tick();
        end

        // T3: simultaneous requests, DMA first, then Z80 with no BGACK gap
        dma_req = 1'b1; z80_win_req = 1'b1; m68k_bg = 1'b1; m68k_as = 1'b0;
        z80_addr = 15'h0042;
        c = 0;
        while (!dma_gnt && c < 10) begin tick(); c++; end
        chk1("T3 dma first", dma_gnt, 1'b1);
        chkw("T3 dma owner", 32'(bus_owner), 32'd2);
        chk1("T3 z80 waits", z80_wait, 1'b1);
        repeat (3) tick();
        dma_req = 1'b0;
        #1;
        chk1("T3 bgack dma", m68k_bgack, 1'b1);
        tick();
        chk1("T3 bgack ack", m68k_bgack, 1'b1);
        chkw("T3 ack owner", 32'(bus_owner), 32'd0);
        tick();
        chk1("T3 bgack z80", m68k_bgack, 1'b1);
        chkw("T3 z80 owner", 32'(bus_owner), 32'd1);
        finish_z80();

        // T5: grant held off while AS is active
        z80_win_req = 1'b1; m68k_bg = 1'b1; m68k_as = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("T5 br held", m68k_br, 1'b1);
            chk1("T5 no bgack", m68k_bgack, 1'b0);
            tick();
        end
        m68k_as = 1'b0;
        #1;
        chk1("T5 br before ack", m68k_br, 1'b1);
        tick();
        chk1("T5 ack bgack", m68k_bgack, 1'b1);
        chk1("T5 ack br", m68k_br, 1'b0);
        finish_z80();

        // T4: BG never returned
        m68k_bg = 1'b0; z80_win_req = 1'b1;
        tick();
        c = 0;
        while (!timeout_err && c < 100) begin tick(); c++; end
        chkw("T4 tcnt at timeout", c, TMO);
        chk1("T4 br during pulse", m68k_br, 1'b1);
        tick();
        chk1("T4 br dropped", m68k_br, 1'b0);
        chk1("T4 tout one clock", timeout_err, 1'b0);
        chk1("T4 wait held", z80_wait, 1'b1);
        z80_win_req = 1'b0;
        repeat (2) tick();

        // T6: reset in the middle of a Z80 access, then bank must be empty
        z80_win_req = 1'b1; m68k_bg = 1'b1; z80_addr = 15'h2222;
        repeat (5) tick();
        chk1("T6 in xfer", m68k_bgack, 1'b1);
        chkw("T6 owner", 32'(bus_owner), 32'd1);
        rst = 1'b1; z80_win_req = 1'b0; m68k_bg = 1'b0;
        tick();
        chk1("T6 br", m68k_br, 1'b0);
        chk1("T6 bgack", m68k_bgack, 1'b0);
        chk1("T6 wait", z80_wait, 1'b0);
        chk1("T6 gnt", dma_gnt, 1'b0);
        chkw("T6 owner0", 32'(bus_owner), 32'd0);
        chkw("T6 addr0", 32'(bus_addr), 32'd0);
        rst = 1'b0;
        z80_addr = 15'h7FFF; z80_win_req = 1'b1; m68k_bg = 1'b1;
        repeat (3) tick();
        chkw("T6 bank cleared", 32'(bus_addr), 32'h007FFF);
        finish_z80();

        // Randomized traffic against the reference model
        lowseen = 1'b0;
        no_bg = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) no_bg = ($urandom % 3 == 0);
            rst = ($urandom % 400 == 0);
            if (z80_win_req) begin
                if (lowseen) z80_win_req = 1'b0;
            end else if ($urandom % 6 == 0) begin
                z80_win_req = 1'b1;
                z80_addr = 15'($urandom);
            end
            if (dma_req) dma_req = ($urandom % 6 != 0);
            else         dma_req = ($urandom % 12 == 0);
            z80_bank_wr  = ($urandom % 5 == 0);
            z80_bank_din = 1'($urandom);
            m68k_bg = no_bg ? 1'b0 : 1'($urandom);
            m68k_as = ($urandom % 3 == 0);
            #1;
            lowseen = z80_win_req && !m_wait();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
